div3_serial_engine: RTL and testbench

- Sequential divide-by-3 engine for 64-bit unsigned operands.
- Streams the dividend MSB-first, DIGIT bits per cycle, through a combinational remainder-carry digit cell, the same family as the per-slice q_* quotient/remainder logic.
- Sits directly upstream of those slices: it sequences digits and carries the 2-bit remainder between steps.
- Valid/ready on both sides; one division in flight.

---
 rtl/div3_pkg.sv | 14 +
 rtl/div3_digit_cell.sv | 33 +++
 rtl/div3_serial_engine.sv | 110 +++++++++++
 tb/tb_div3_serial_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/div3_pkg.sv
// Shared definitions for the serial divide-by-3 engine and its digit cell.
package div3_pkg;
   localparam int DIV3_WIDTH = 64;
   localparam int DIV3_DIGIT = 4;
   localparam int DIV3_STEPS = DIV3_WIDTH / DIV3_DIGIT;

   typedef logic [1:0] rem_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/div3_digit_cell.sv
// Combinational remainder-carry digit: {r_in, d} / 3, with a legal r_in of 0..2.
module div3_digit_cell
   import div3_pkg::*;
#(
   parameter int DIGIT = DIV3_DIGIT
) (
   input  logic [1:0]       r_in,
   input  logic [DIGIT-1:0] d,
   output logic [DIGIT-1:0] q_digit,
   output logic [1:0]       r_out
);

   logic [2:0] t;
   logic [1:0] r;

   // Restoring long division one bit at a time; the partial remainder stays below 3.
   always_comb begin
      r       = r_in;
      t       = '0;
      q_digit = '0;
      for (int i = DIGIT - 1; i >= 0; i--) begin
         t = {r, d[i]};
         if (t >= 3'd3) begin
            q_digit[i] = 1'b1;
            r          = 2'(t - 3'd3);
         end else begin
            r = t[1:0];
         end
      end
      r_out = r;
   end

endmodule

// File: rtl/div3_serial_engine.sv
// Serial divide-by-3: streams the dividend MSB-first, DIGIT bits per cycle, one division in flight.
module div3_serial_engine
   import div3_pkg::*;
#(
   parameter int WIDTH = DIV3_WIDTH,
   parameter int DIGIT = DIV3_DIGIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dividend,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [1:0]       out_remainder
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

   logic [1:0]       rst_sync_q;
   logic             rst_ni;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   rem_t             rem_q, rem_d;
   rem_t             remo_q, remo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIGIT-1:0] q_digit;
   rem_t             r_next;
   logic [WIDTH-1:0] shifted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_ni = rst_sync_q[1];

   div3_digit_cell #(.DIGIT(DIGIT)) u_cell (
      .r_in    (rem_q),
      .d       (shreg_q[WIDTH-1 -: DIGIT]),
      .q_digit (q_digit),
      .r_out   (r_next)
   );

   // Dividend digits leave at the top while quotient digits enter at the bottom.
   assign shifted = {shreg_q[WIDTH-DIGIT-1:0], q_digit};

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      remo_d  = remo_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               shreg_d = in_dividend;
               rem_d   = '0;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            shreg_d = shifted;
            rem_d   = r_next;
            if (cnt_q == LAST) begin
               quo_d   = shifted;
               remo_d  = r_next;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         shreg_q <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         remo_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         remo_q  <= remo_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = (state_q == DONE);
   assign out_quotient  = quo_q;
   assign out_remainder = remo_q;

   a_rem_legal : assert property (@(posedge clk) disable iff (!rst_ni) rem_q != 2'd3);

endmodule

// File: tb/tb_div3_serial_engine.sv
// Scoreboard bench for div3_serial_engine: directed cases, reset abort and random traffic.
module tb_div3_serial_engine;

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_dividend;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_quotient;
   logic [1:0]  out_remainder;

   logic [1:0]  c_r;
   logic [3:0]  c_d;
   logic [3:0]  c_q;
   logic [1:0]  c_ro;

   int   n_cmp = 0;
   int   n_err = 0;
   int   mode  = 0;   // 0: always ready, 1: random ready, 2: hold ready low
   exp_t sb[$];

   always #5 clk = ~clk;

   div3_serial_engine dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_dividend   (in_dividend),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder)
   );

   div3_digit_cell #(.DIGIT(4)) u_cell_chk (
      .r_in    (c_r),
      .d       (c_d),
      .q_digit (c_q),
      .r_out   (c_ro)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: bound expired", nm);
   endtask

   // Monitor: choose out_ready for the coming edge, then score any handshake it implies.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_result: got q=%h r=%0d, expected no result", out_quotient, out_remainder);
            end else begin
               e = sb.pop_front();
               chk("quotient", out_quotient, e.q);
               chk("remainder", {62'd0, out_remainder}, e.r);
            end
         end
      end
   end

   task automatic send(input logic [63:0] a);
      int   n = 0;
      exp_t e;
      in_valid    = 1'b1;
      in_dividend = a;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         fail_now("accept_timeout");
         in_valid = 1'b0;
         return;
      end
      e.q = a / 64'd3;
      e.r = a % 64'd3;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) fail_now("drain_timeout");
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          n;
      int          v;
      logic [63:0] a;

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_dividend = '0;
      c_r         = '0;
      c_d         = '0;

      // Digit cell against plain arithmetic over every legal input pair.
      for (int r = 0; r < 3; r++) begin
         for (int d = 0; d < 16; d++) begin
            c_r = 2'(r);
            c_d = 4'(d);
            #1;
            v = r * 16 + d;
            chk("cell_q", {60'd0, c_q}, 64'(v / 3));
            chk("cell_r", {62'd0, c_ro}, 64'(v % 3));
         end
      end

      repeat (3) @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_quotient", out_quotient, 64'd0);
      chk("rst_remainder", {62'd0, out_remainder}, 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Latency: accept in cycle 0, result visible in cycle 17.
      mode = 0;
      send(64'd0);
      n = 1;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 64'(n), 64'd17);
      wait_idle();

      send(64'd100);
      wait_idle();
      send(64'hFFFF_FFFF_FFFF_FFFF);
      wait_idle();

      // Result must hold steady while the consumer stalls.
      mode = 2;
      send(64'h8000_0000_0000_0000);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) fail_now("hold_wait");
      for (int k = 0; k < 10; k++) begin
         chk("hold_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
         chk("hold_quotient", out_quotient, 64'h2AAA_AAAA_AAAA_AAAA);
         chk("hold_remainder", {62'd0, out_remainder}, 64'd2);
         @(negedge clk);
      end
      mode = 0;
      wait_idle();

      // Abort mid-division with reset.
      send(64'h1234_5678_9ABC_DEF0);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
      chk("abort_quotient", out_quotient, 64'd0);
      chk("abort_remainder", {62'd0, out_remainder}, 64'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      send(64'd7);
      wait_idle();

      // Random traffic with a randomly stalling consumer.
      mode = 1;
      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 3))
            0:       a = 64'($urandom_range(0, 20));
            1:       a = ~64'($urandom_range(0, 20));
            default: a = {$urandom, $urandom};
         endcase
         send(a);
      end
      wait_idle();
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
